// File: rtl/i2c_target_regs_pkg.sv
// Shared types and constants for the I2C register target.
// Imported by the line conditioner and the target top level.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        WDATA,
        RDATA,
        WAIT_STOP
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int SYNC_STAGES = 2;

    function automatic logic majority3(logic a, logic b, logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_target_regs_if.sv
// I2C pad bundle between the target and the open-drain bus.
// slave = the target side, master = the bus/pad side.
interface i2c_target_regs_if;

    logic i2c_scl_i;
    logic i2c_scl_o;
    logic i2c_scl_t;
    logic i2c_sda_i;
    logic i2c_sda_o;
    logic i2c_sda_t;

    modport slave (
        input  i2c_scl_i,
        input  i2c_sda_i,
        output i2c_scl_o,
        output i2c_scl_t,
        output i2c_sda_o,
        output i2c_sda_t
    );

    modport master (
        output i2c_scl_i,
        output i2c_sda_i,
        input  i2c_scl_o,
        input  i2c_scl_t,
        input  i2c_sda_o,
        input  i2c_sda_t
    );

endinterface

// File: rtl/i2c_target_regs_line_cond.sv
// SCL/SDA synchronizers, optional majority glitch filter and edge/START/STOP detect.
// Macro I2C_TARGET_REGS_GLITCH_FILTER_EN adds a 3-sample majority filter per line.
module i2c_line_cond
    import i2c_target_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic scl_pad,
    input  logic sda_pad,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_line;
    logic                   sda_line;
    logic                   scl_prev;
    logic                   sda_prev;

    // Two-flop synchronizers; idle bus level is high
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pad};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pad};
        end
    end

`ifdef I2C_TARGET_REGS_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;

    // Majority of the current and two previous samples, registered
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_line <= 1'b1;
            sda_line <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[SYNC_STAGES-1]};
            sda_hist <= {sda_hist[0], sda_sync[SYNC_STAGES-1]};
            scl_line <= majority3(scl_sync[SYNC_STAGES-1], scl_hist[0], scl_hist[1]);
            sda_line <= majority3(sda_sync[SYNC_STAGES-1], sda_hist[0], sda_hist[1]);
        end
    end
`else
    assign scl_line = scl_sync[SYNC_STAGES-1];
    assign sda_line = sda_sync[SYNC_STAGES-1];
`endif

    // Previous conditioned levels for edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_line;
            sda_prev <= sda_line;
        end
    end

    assign sda      = sda_line;
    assign scl_rise = scl_line & ~scl_prev;
    assign scl_fall = ~scl_line & scl_prev;
    assign start    = scl_line & scl_prev & sda_prev & ~sda_line;
    assign stop     = scl_line & scl_prev & ~sda_prev & sda_line;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register bank, pointer writes and auto-increment reads.
// Optional glitch filter lives in i2c_line_cond (I2C_TARGET_REGS_GLITCH_FILTER_EN).
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         NUM_REGS    = 16,
    localparam int        PTR_W       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             resetn,
    i2c_target_regs_if.slave i2c,
    input  logic [PTR_W-1:0] host_addr,
    output logic [7:0]       host_rdata,
    input  logic             host_we,
    input  logic [7:0]       host_wdata,
    output logic             i2c_wr_valid,
    output logic [PTR_W-1:0] i2c_wr_addr,
    output logic [7:0]       i2c_wr_data,
    output logic             busy
);

    state_t           state;
    logic [3:0]       cnt;
    logic [7:0]       shreg;
    logic [PTR_W-1:0] ptr;
    logic             rw;
    logic             sda_drive;
    logic [7:0]       regs [NUM_REGS];

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic commit;

    i2c_line_cond u_line_cond (
        .clk      (clk),
        .resetn   (resetn),
        .scl_pad  (i2c.i2c_scl_i),
        .sda_pad  (i2c.i2c_sda_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign i2c.i2c_scl_o = 1'b0;
    assign i2c.i2c_scl_t = 1'b1;
    assign i2c.i2c_sda_o = 1'b0;
    assign i2c.i2c_sda_t = sda_drive;

    assign host_rdata = regs[host_addr];

    assign commit = (state == WDATA) && scl_fall && (cnt == 4'd8)
                    && !start && !stop;

    // Register bank; an I2C commit overrides a same-index host write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (host_we) regs[host_addr] <= host_wdata;
            if (commit) regs[ptr] <= shreg;
        end
    end

    // Protocol FSM: bits in on SCL rise, SDA changes only after SCL fall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            ptr          <= '0;
            rw           <= 1'b0;
            sda_drive    <= 1'b1;
            busy         <= 1'b0;
            i2c_wr_valid <= 1'b0;
            i2c_wr_addr  <= '0;
            i2c_wr_data  <= '0;
        end else begin
            i2c_wr_valid <= 1'b0;
            if (stop) begin
                state     <= IDLE;
                cnt       <= '0;
                sda_drive <= 1'b1;
                busy      <= 1'b0;
            end else if (start) begin
                state     <= ADDR;
                cnt       <= '0;
                sda_drive <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise && cnt < 4'd8) begin
                            shreg <= {shreg[6:0], sda};
                            cnt   <= cnt + 4'd1;
                        end else if (scl_fall && cnt == 4'd8) begin
                            if (shreg[7:1] == TARGET_ADDR) begin
                                sda_drive <= ACK;
                                busy      <= 1'b1;
                                rw        <= shreg[0];
                                state     <= ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            cnt <= '0;
                            if (rw) begin
                                shreg     <= regs[ptr];
                                sda_drive <= regs[ptr][7];
                                state     <= RDATA;
                            end else begin
                                sda_drive <= 1'b1;
                                state     <= PTR;
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise && cnt < 4'd8) begin
                            shreg <= {shreg[6:0], sda};
                            cnt   <= cnt + 4'd1;
                        end else if (scl_fall && cnt == 4'd8) begin
                            ptr       <= shreg[PTR_W-1:0];
                            sda_drive <= ACK;
                            cnt       <= 4'd9;
                        end else if (scl_fall && cnt == 4'd9) begin
                            sda_drive <= 1'b1;
                            cnt       <= '0;
                            state     <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (scl_rise && cnt < 4'd8) begin
                            shreg <= {shreg[6:0], sda};
                            cnt   <= cnt + 4'd1;
                        end else if (commit) begin
                            i2c_wr_valid <= 1'b1;
                            i2c_wr_addr  <= ptr;
                            i2c_wr_data  <= shreg;
                            ptr          <= ptr + 1'b1;
                            sda_drive    <= ACK;
                            cnt          <= 4'd9;
                        end else if (scl_fall && cnt == 4'd9) begin
                            sda_drive <= 1'b1;
                            cnt       <= '0;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            if (cnt < 4'd8) begin
                                cnt <= cnt + 4'd1;
                            end else if (cnt == 4'd8) begin
                                if (sda == NACK) begin
                                    state <= WAIT_STOP;
                                end else begin
                                    ptr <= ptr + 1'b1;
                                    cnt <= 4'd9;
                                end
                            end
                        end else if (scl_fall) begin
                            if (cnt >= 4'd1 && cnt <= 4'd7) begin
                                shreg     <= {shreg[6:0], 1'b0};
                                sda_drive <= shreg[6];
                            end else if (cnt == 4'd8) begin
                                sda_drive <= 1'b1;
                            end else if (cnt == 4'd9) begin
                                shreg     <= regs[ptr];
                                sda_drive <= regs[ptr][7];
                                cnt       <= '0;
                            end
                        end
                    end
                    WAIT_STOP: sda_drive <= 1'b1;
                    default:   state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Scoreboard bench for i2c_target_regs: bus-level master, model register bank,
// monitors checking SDA per bit slot and every i2c_wr_valid pulse.
module tb_i2c_target_regs;
    import i2c_target_pkg::*;

    localparam int CLK = 10;
    localparam int Q   = 8 * CLK;
`ifdef I2C_TARGET_REGS_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] host_addr;
    logic [7:0] host_rdata;
    logic       host_we;
    logic [7:0] host_wdata;
    logic       i2c_wr_valid;
    logic [3:0] i2c_wr_addr;
    logic [7:0] i2c_wr_data;
    logic       busy;

    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic in_bit = 1'b0;

    always #(CLK/2) clk = ~clk;

    i2c_target_regs_if ifc();

    assign ifc.i2c_scl_i = scl_m & (ifc.i2c_scl_t | ifc.i2c_scl_o);
    assign ifc.i2c_sda_i = sda_m & (ifc.i2c_sda_t | ifc.i2c_sda_o);

    i2c_target_regs #(.TARGET_ADDR(7'h50), .NUM_REGS(16)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i2c          (ifc),
        .host_addr    (host_addr),
        .host_rdata   (host_rdata),
        .host_we      (host_we),
        .host_wdata   (host_wdata),
        .i2c_wr_valid (i2c_wr_valid),
        .i2c_wr_addr  (i2c_wr_addr),
        .i2c_wr_data  (i2c_wr_data),
        .busy         (busy)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    int    tests = 0;
    int    fails = 0;
    logic  exp_q[$];
    string tag_q[$];
    wr_t   exp_wr[$];
    logic [7:0] wq[$];
    logic [7:0] mregs[16];
    int    mptr = 0;
    logic [3:0] coll_addr;
    logic [7:0] coll_data;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: SDA tristate in every master clocked bit slot
    always @(posedge scl_m) begin
        if (in_bit) begin
            if (exp_q.size() == 0) begin
                check("sda_slot_underflow", 1, 0);
            end else begin
                check(tag_q.pop_front(), ifc.i2c_sda_t, exp_q.pop_front());
            end
        end
    end

    // Monitor: every committed I2C write against the expected stream
    always @(negedge clk) begin
        if (resetn && i2c_wr_valid) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                check("wr_addr", i2c_wr_addr, e.a);
                check("wr_data", i2c_wr_data, e.d);
            end
        end
    end

    initial begin
        #(90000 * CLK);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic mbit(input logic b, input logic exp_t, input string tag);
        #Q sda_m = b;
        exp_q.push_back(exp_t);
        tag_q.push_back(tag);
        in_bit = 1'b1;
        #Q scl_m = 1'b1;
        #(2*Q) scl_m = 1'b0;
        in_bit = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack,
                             input string tag, input bit coll);
        for (int i = 7; i >= 0; i--) mbit(b[i], 1'b1, {tag, "_bit"});
        if (coll) begin
            fork
                begin
                    #((LAT-1)*CLK);
                    host_addr = coll_addr;
                    host_wdata = coll_data;
                    host_we = 1'b1;
                    #CLK host_we = 1'b0;
                end
            join_none
        end
        mbit(1'b1, ack, {tag, "_ack"});
    endtask

    task automatic recv_byte(input logic [7:0] d, input logic mack);
        for (int i = 7; i >= 0; i--) mbit(1'b1, d[i], "rd_bit");
        mbit(mack, 1'b1, "rd_mack_released");
    endtask

    task automatic i2c_start();
        @(negedge clk);
        sda_m = 1'b0;
        #(2*Q) scl_m = 1'b0;
    endtask

    task automatic i2c_rstart();
        #Q sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #(2*Q);
    endtask

    task automatic host_write(input int a, input logic [7:0] v);
        @(negedge clk);
        host_addr = a[3:0];
        host_wdata = v;
        host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
        mregs[a] = v;
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            host_addr = i[3:0];
            #1 check(name, host_rdata, mregs[i]);
        end
        @(negedge clk);
    endtask

    task automatic i2c_write(input logic [7:0] p);
        i2c_start();
        send_byte({7'h50, 1'b0}, ACK, "addr_w", 0);
        check("busy_after_addr", busy, 1);
        send_byte(p, ACK, "ptr", 0);
        mptr = p % 16;
        foreach (wq[i]) begin
            exp_wr.push_back({mptr[3:0], wq[i]});
            mregs[mptr] = wq[i];
            send_byte(wq[i], ACK, "wdata", 0);
            mptr = (mptr + 1) % 16;
        end
        i2c_stop();
        check("busy_after_stop", busy, 0);
    endtask

    task automatic i2c_read(input bit set_ptr, input logic [7:0] p, input int n);
        i2c_start();
        if (set_ptr) begin
            send_byte({7'h50, 1'b0}, ACK, "addr_w", 0);
            send_byte(p, ACK, "ptr", 0);
            mptr = p % 16;
            i2c_rstart();
        end
        send_byte({7'h50, 1'b1}, ACK, "addr_r", 0);
        for (int i = 0; i < n; i++) begin
            recv_byte(mregs[mptr], (i == n - 1) ? NACK : ACK);
            if (i != n - 1) mptr = (mptr + 1) % 16;
        end
        i2c_stop();
        check("sda_released_after_read", ifc.i2c_sda_t, 1);
        check("busy_after_read", busy, 0);
    endtask

    task automatic collide(input logic [7:0] p, input logic [7:0] v,
                           input logic [3:0] ha, input logic [7:0] hv);
        i2c_start();
        send_byte({7'h50, 1'b0}, ACK, "addr_w", 0);
        send_byte(p, ACK, "ptr", 0);
        coll_addr = ha;
        coll_data = hv;
        if (ha != p[3:0]) mregs[ha] = hv;
        mregs[p[3:0]] = v;
        exp_wr.push_back({p[3:0], v});
        send_byte(v, ACK, "coll_wdata", 1);
        mptr = (p + 1) % 16;
        i2c_stop();
    endtask

    initial begin
        resetn = 1'b0;
        host_addr = '0;
        host_we = 1'b0;
        host_wdata = '0;
        foreach (mregs[i]) mregs[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_sda_t", ifc.i2c_sda_t, 1);
        check("rst_scl_t", ifc.i2c_scl_t, 1);
        check("rst_wr_valid", i2c_wr_valid, 0);
        check("rst_busy", busy, 0);
        check_regs("rst_regs");
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        wq.delete();
        wq.push_back(8'h11);
        wq.push_back(8'h22);
        i2c_write(8'h03);
        check_regs("write_regs");

        i2c_start();
        send_byte(8'hA2, NACK, "wrong_addr", 0);
        check("busy_wrong_addr", busy, 0);
        send_byte(8'h00, NACK, "wrong_data", 0);
        i2c_stop();
        check("busy_wrong_stop", busy, 0);
        check_regs("wrong_regs");

        host_write(15, 8'h5A);
        host_write(0, 8'hC3);
        i2c_read(1, 8'h0F, 2);

        i2c_start();
        send_byte({7'h50, 1'b0}, ACK, "addr_w", 0);
        send_byte(8'h06, ACK, "ptr", 0);
        mptr = 6;
        for (int i = 0; i < 5; i++) mbit(1'b1, 1'b1, "abort_bit");
        i2c_stop();
        check("abort_busy", busy, 0);
        check("abort_state", dut.state, IDLE);
        check_regs("abort_regs");

        collide(8'h02, 8'h99, 4'd2, 8'h77);
        collide(8'h08, 8'h44, 4'd5, 8'h66);
        check_regs("coll_regs");

        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 3))
                0: host_write($urandom_range(0, 15), 8'($urandom));
                1: begin
                    wq.delete();
                    for (int k = 0; k < $urandom_range(1, 3); k++)
                        wq.push_back(8'($urandom));
                    i2c_write(8'($urandom));
                end
                2: i2c_read(1, 8'($urandom), $urandom_range(1, 4));
                default: i2c_read(0, 8'h00, $urandom_range(1, 3));
            endcase
        end
        check_regs("rand_regs");

        host_write(7, 8'h00);
        i2c_start();
        send_byte({7'h50, 1'b0}, ACK, "addr_w", 0);
        send_byte(8'h07, ACK, "ptr", 0);
        i2c_rstart();
        send_byte({7'h50, 1'b1}, ACK, "addr_r", 0);
        mbit(1'b1, 1'b0, "rd_bit");
        mbit(1'b1, 1'b0, "rd_bit");
        #Q;
        check("pre_reset_drive", ifc.i2c_sda_t, 0);
        resetn = 1'b0;
        #1 check("async_reset_release", ifc.i2c_sda_t, 1);
        scl_m = 1'b1;
        sda_m = 1'b1;
        foreach (mregs[i]) mregs[i] = '0;
        mptr = 0;
        check("reset_busy", busy, 0);
        check_regs("reset_regs");
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_state", dut.state, IDLE);

        host_write(1, 8'hA5);
        i2c_read(0, 8'h00, 2);

        check_regs("final_regs");
        check("sda_queue_empty", exp_q.size(), 0);
        check("wr_queue_empty", exp_wr.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
